// File: rtl/camera_power_sequencer.sv
// rtl/camera_power_sequencer.sv - camera power-rail sequencer with power-good gating and timeout fault (optional CAM_PG_MONITOR_EN)
module camera_power_sequencer #(
    parameter int NUM_STEPS  = 5,
    parameter int STEP_DELAY = 1000000,
    parameter int PG_TIMEOUT = 2000000,
    parameter int CNT_W      = 32
) (
    input  logic                 ctrl_clk_i,
    input  logic                 ctrl_rst_n_i,
    input  logic                 pwr_req_i,
    input  logic [NUM_STEPS-1:0] pg_i,
    input  logic                 fault_clr_i,
    output logic [NUM_STEPS-1:0] en_o,
    output logic                 pwr_up_o,
    output logic                 busy_o,
    output logic                 fault_o,
    output logic [3:0]           fault_step_o
);

    typedef enum logic [2:0] {
        S_OFF,
        S_RAMP_UP,
        S_ON,
        S_RAMP_DOWN,
        S_FAULT
    } state_t;

    state_t               state_q, state_d;
    logic [3:0]           idx_q, idx_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [NUM_STEPS-1:0] en_q, en_d;
    logic                 pwr_up_q, pwr_up_d;
    logic                 busy_q, busy_d;
    logic                 fault_q, fault_d;
    logic [3:0]           fault_step_q, fault_step_d;

    logic [NUM_STEPS-1:0] step_bit;
    logic                 pg_cur;
    logic                 delay_done;
    logic                 timeout;
    logic                 last_step;
    logic [CNT_W-1:0]     cnt_inc;

`ifdef CAM_PG_MONITOR_EN
    logic [NUM_STEPS-1:0] pg_low_q, pg_low_d;
    logic [NUM_STEPS-1:0] mon_hit;
    logic [3:0]           mon_idx;

    // Flag rails that have been low on two consecutive ON-state samples; report the lowest one
    always_comb begin
        pg_low_d = (state_q == S_ON) ? ~pg_i : '0;
        mon_hit  = ~pg_i & pg_low_q;
        mon_idx  = 4'd0;
        for (int i = NUM_STEPS - 1; i >= 0; i--) begin
            if (mon_hit[i]) begin
                mon_idx = 4'(i);
            end
        end
    end
`endif

    // Decode the current step as a one-hot mask so index width never has to match NUM_STEPS
    always_comb begin
        step_bit   = NUM_STEPS'(1) << idx_q;
        pg_cur     = |(pg_i & step_bit);
        delay_done = cnt_q >= CNT_W'(STEP_DELAY - 1);
        timeout    = cnt_q == CNT_W'(PG_TIMEOUT - 1);
        last_step  = idx_q == 4'(NUM_STEPS - 1);
        cnt_inc    = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Next-state and registered-output decisions; a request reversal always wins over advance/timeout
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        en_d         = en_q;
        pwr_up_d     = pwr_up_q;
        busy_d       = busy_q;
        fault_d      = fault_q;
        fault_step_d = fault_step_q;
        case (state_q)
            S_OFF: begin
                if (pwr_req_i) begin
                    state_d = S_RAMP_UP;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                    en_d    = NUM_STEPS'(1);
                    busy_d  = 1'b1;
                end
            end
            S_RAMP_UP: begin
                if (!pwr_req_i) begin
                    state_d = S_RAMP_DOWN;
                    en_d    = en_q & ~step_bit;
                    cnt_d   = '0;
                end else if (delay_done && pg_cur) begin
                    cnt_d = '0;
                    if (last_step) begin
                        state_d  = S_ON;
                        pwr_up_d = 1'b1;
                        busy_d   = 1'b0;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        en_d  = en_q | (step_bit << 1);
                    end
                end else if (timeout && !pg_cur) begin
                    state_d      = S_FAULT;
                    en_d         = '0;
                    fault_d      = 1'b1;
                    fault_step_d = idx_q;
                    busy_d       = 1'b0;
                    pwr_up_d     = 1'b0;
                    cnt_d        = '0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_ON: begin
`ifdef CAM_PG_MONITOR_EN
                if (|mon_hit) begin
                    state_d      = S_FAULT;
                    en_d         = '0;
                    fault_d      = 1'b1;
                    fault_step_d = mon_idx;
                    busy_d       = 1'b0;
                    pwr_up_d     = 1'b0;
                    cnt_d        = '0;
                end else
`endif
                if (!pwr_req_i) begin
                    state_d  = S_RAMP_DOWN;
                    idx_d    = 4'(NUM_STEPS - 1);
                    en_d     = en_q >> 1;
                    cnt_d    = '0;
                    pwr_up_d = 1'b0;
                    busy_d   = 1'b1;
                end
            end
            S_RAMP_DOWN: begin
                if (pwr_req_i) begin
                    state_d = S_RAMP_UP;
                    en_d    = en_q | step_bit;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(STEP_DELAY - 1)) begin
                    cnt_d = '0;
                    if (idx_q == 4'd0) begin
                        state_d = S_OFF;
                        busy_d  = 1'b0;
                    end else begin
                        idx_d = idx_q - 4'd1;
                        en_d  = en_q & ~(step_bit >> 1);
                    end
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_FAULT: begin
                if (fault_clr_i && !pwr_req_i) begin
                    state_d = S_OFF;
                    fault_d = 1'b0;
                    idx_d   = 4'd0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_OFF;
                en_d    = '0;
            end
        endcase
    end

    // State register; reset drops every enable at once with no ramp-down
    always_ff @(posedge ctrl_clk_i) begin
        if (!ctrl_rst_n_i) begin
            state_q      <= S_OFF;
            idx_q        <= 4'd0;
            cnt_q        <= '0;
            en_q         <= '0;
            pwr_up_q     <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
            fault_step_q <= 4'd0;
`ifdef CAM_PG_MONITOR_EN
            pg_low_q     <= '0;
`endif
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            en_q         <= en_d;
            pwr_up_q     <= pwr_up_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
            fault_step_q <= fault_step_d;
`ifdef CAM_PG_MONITOR_EN
            pg_low_q     <= pg_low_d;
`endif
        end
    end

    assign en_o         = en_q;
    assign pwr_up_o     = pwr_up_q;
    assign busy_o       = busy_q;
    assign fault_o      = fault_q;
    assign fault_step_o = fault_step_q;

endmodule

// File: tb/tb_camera_power_sequencer.sv
// tb/tb_camera_power_sequencer.sv - self-checking bench for camera_power_sequencer
module tb_camera_power_sequencer;

    localparam int N  = 3;
    localparam int SD = 4;
    localparam int PT = 10;

    localparam int P_OFF = 0;
    localparam int P_UP  = 1;
    localparam int P_ON  = 2;
    localparam int P_DN  = 3;
    localparam int P_FLT = 4;

    logic         clk  = 1'b0;
    logic         rstn = 1'b0;
    logic         req  = 1'b0;
    logic         clr  = 1'b0;
    logic [N-1:0] pg   = 3'b111;
    logic [N-1:0] en;
    logic         pwr_up;
    logic         busy;
    logic         fault;
    logic [3:0]   fs;

    int total = 0;
    int bad   = 0;

    // reference model: number of rails on, phase, step timer, fault latch
    int m_ph;
    int m_lv;
    int m_t;
    int m_fs;
    bit m_flt;
    int m_low [N];

    always #5 clk = ~clk;

    camera_power_sequencer #(
        .NUM_STEPS (N),
        .STEP_DELAY(SD),
        .PG_TIMEOUT(PT),
        .CNT_W     (8)
    ) dut (
        .ctrl_clk_i  (clk),
        .ctrl_rst_n_i(rstn),
        .pwr_req_i   (req),
        .pg_i        (pg),
        .fault_clr_i (clr),
        .en_o        (en),
        .pwr_up_o    (pwr_up),
        .busy_o      (busy),
        .fault_o     (fault),
        .fault_step_o(fs)
    );

    function automatic logic [9:0] outs();
        return {en, pwr_up, busy, fault, fs};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic model_step(input logic r_n, input logic rq, input logic cl, input logic [N-1:0] p);
        bit mon;
        int mon_i;
        if (!r_n) begin
            m_ph = P_OFF; m_lv = 0; m_t = 0; m_flt = 0; m_fs = 0;
            for (int i = 0; i < N; i++) m_low[i] = 0;
            return;
        end
        mon = 0;
        mon_i = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m_ph == P_ON && !p[i]) m_low[i] = m_low[i] + 1;
            else m_low[i] = 0;
            if (m_low[i] >= 2) begin
                mon = 1;
                mon_i = i;
            end
        end
`ifndef CAM_PG_MONITOR_EN
        mon = 0;
`endif
        case (m_ph)
            P_OFF: if (rq) begin m_ph = P_UP; m_lv = 1; m_t = 0; end
            P_UP: begin
                if (!rq) begin
                    m_ph = P_DN; m_lv = m_lv - 1; m_t = 0;
                end else if (m_t >= SD - 1 && p[m_lv-1]) begin
                    if (m_lv == N) m_ph = P_ON;
                    else m_lv = m_lv + 1;
                    m_t = 0;
                end else if (m_t == PT - 1) begin
                    m_ph = P_FLT; m_flt = 1; m_fs = m_lv - 1; m_lv = 0;
                end else begin
                    m_t = m_t + 1;
                end
            end
            P_ON: begin
                if (mon) begin
                    m_ph = P_FLT; m_flt = 1; m_fs = mon_i; m_lv = 0;
                end else if (!rq) begin
                    m_ph = P_DN; m_lv = N - 1; m_t = 0;
                end
            end
            P_DN: begin
                if (rq) begin
                    m_ph = P_UP; m_lv = m_lv + 1; m_t = 0;
                end else if (m_t == SD - 1) begin
                    if (m_lv == 0) m_ph = P_OFF;
                    else m_lv = m_lv - 1;
                    m_t = 0;
                end else begin
                    m_t = m_t + 1;
                end
            end
            default: if (cl && !rq) begin m_ph = P_OFF; m_flt = 0; end
        endcase
    endtask

    task automatic test_reset();
        rstn = 1'b0; req = 1'b0; clr = 1'b0; pg = 3'b111;
        tick(2);
        total++;
        if (outs() !== 10'b0) begin
            bad++; $display("FAIL reset got=%b exp=%b", outs(), 10'b0);
        end
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic test_power_up();
        req = 1'b1;
        tick(1);
        total++;
        if (outs() !== {3'b001, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL up_E got=%b exp=%b", outs(), {3'b001, 1'b0, 1'b1, 1'b0, 4'd0});
        end
        tick(4);
        total++;
        if (outs() !== {3'b011, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL up_E4 got=%b exp=%b", outs(), {3'b011, 1'b0, 1'b1, 1'b0, 4'd0});
        end
        tick(4);
        total++;
        if (outs() !== {3'b111, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL up_E8 got=%b exp=%b", outs(), {3'b111, 1'b0, 1'b1, 1'b0, 4'd0});
        end
        tick(4);
        total++;
        if (outs() !== {3'b111, 1'b1, 1'b0, 1'b0, 4'd0}) begin
            bad++; $display("FAIL up_E12 got=%b exp=%b", outs(), {3'b111, 1'b1, 1'b0, 1'b0, 4'd0});
        end
    endtask

    task automatic test_power_down();
        req = 1'b0;
        tick(1);
        total++;
        if (outs() !== {3'b011, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL dn_D got=%b exp=%b", outs(), {3'b011, 1'b0, 1'b1, 1'b0, 4'd0});
        end
        tick(4);
        total++;
        if (outs() !== {3'b001, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL dn_D4 got=%b exp=%b", outs(), {3'b001, 1'b0, 1'b1, 1'b0, 4'd0});
        end
        tick(4);
        total++;
        if (outs() !== {3'b000, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL dn_D8 got=%b exp=%b", outs(), {3'b000, 1'b0, 1'b1, 1'b0, 4'd0});
        end
        tick(4);
        total++;
        if (outs() !== 10'b0) begin
            bad++; $display("FAIL dn_D12 got=%b exp=%b", outs(), 10'b0);
        end
    endtask

    task automatic test_timeout();
        pg = 3'b101; req = 1'b1;
        tick(5);
        total++;
        if (outs() !== {3'b011, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL to_E4 got=%b exp=%b", outs(), {3'b011, 1'b0, 1'b1, 1'b0, 4'd0});
        end
        tick(9);
        total++;
        if (outs() !== {3'b011, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            bad++; $display("FAIL to_E13 got=%b exp=%b", outs(), {3'b011, 1'b0, 1'b1, 1'b0, 4'd0});
        end
        tick(1);
        total++;
        if (outs() !== {3'b000, 1'b0, 1'b0, 1'b1, 4'd1}) begin
            bad++; $display("FAIL to_E14 got=%b exp=%b", outs(), {3'b000, 1'b0, 1'b0, 1'b1, 4'd1});
        end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        total++;
        if (outs() !== {3'b000, 1'b0, 1'b0, 1'b1, 4'd1}) begin
            bad++; $display("FAIL to_clr_req1 got=%b exp=%b", outs(), {3'b000, 1'b0, 1'b0, 1'b1, 4'd1});
        end
        clr = 1'b1; req = 1'b0;
        tick(1);
        clr = 1'b0; pg = 3'b111;
        total++;
        if (outs() !== {3'b000, 1'b0, 1'b0, 1'b0, 4'd1}) begin
            bad++; $display("FAIL to_clr_req0 got=%b exp=%b", outs(), {3'b000, 1'b0, 1'b0, 1'b0, 4'd1});
        end
        tick(2);
    endtask

    task automatic test_slow_pg();
        pg = 3'b011; req = 1'b1;
        tick(9);
        total++;
        if (outs() !== {3'b111, 1'b0, 1'b1, 1'b0, 4'd1}) begin
            bad++; $display("FAIL slow_E8 got=%b exp=%b", outs(), {3'b111, 1'b0, 1'b1, 1'b0, 4'd1});
        end
        tick(6);
        total++;
        if (outs() !== {3'b111, 1'b0, 1'b1, 1'b0, 4'd1}) begin
            bad++; $display("FAIL slow_E14 got=%b exp=%b", outs(), {3'b111, 1'b0, 1'b1, 1'b0, 4'd1});
        end
        pg = 3'b111;
        tick(2);
        total++;
        if (outs() !== {3'b111, 1'b1, 1'b0, 1'b0, 4'd1}) begin
            bad++; $display("FAIL slow_on got=%b exp=%b", outs(), {3'b111, 1'b1, 1'b0, 1'b0, 4'd1});
        end
        req = 1'b0;
        tick(13);
        total++;
        if (outs() !== {3'b000, 1'b0, 1'b0, 1'b0, 4'd1}) begin
            bad++; $display("FAIL slow_off got=%b exp=%b", outs(), {3'b000, 1'b0, 1'b0, 1'b0, 4'd1});
        end
    endtask

    task automatic test_reversal();
        req = 1'b1;
        tick(5);
        total++;
        if (outs() !== {3'b011, 1'b0, 1'b1, 1'b0, 4'd1}) begin
            bad++; $display("FAIL rev_E4 got=%b exp=%b", outs(), {3'b011, 1'b0, 1'b1, 1'b0, 4'd1});
        end
        req = 1'b0;
        tick(1);
        total++;
        if (outs() !== {3'b001, 1'b0, 1'b1, 1'b0, 4'd1}) begin
            bad++; $display("FAIL rev_first got=%b exp=%b", outs(), {3'b001, 1'b0, 1'b1, 1'b0, 4'd1});
        end
        tick(4);
        total++;
        if (outs() !== {3'b000, 1'b0, 1'b1, 1'b0, 4'd1}) begin
            bad++; $display("FAIL rev_second got=%b exp=%b", outs(), {3'b000, 1'b0, 1'b1, 1'b0, 4'd1});
        end
        tick(4);
        total++;
        if (outs() !== {3'b000, 1'b0, 1'b0, 1'b0, 4'd1}) begin
            bad++; $display("FAIL rev_off got=%b exp=%b", outs(), {3'b000, 1'b0, 1'b0, 1'b0, 4'd1});
        end
        req = 1'b1;
        tick(6);
        rstn = 1'b0;
        tick(1);
        total++;
        if (outs() !== 10'b0) begin
            bad++; $display("FAIL rev_reset got=%b exp=%b", outs(), 10'b0);
        end
        rstn = 1'b1; req = 1'b0;
        tick(1);
    endtask

    task automatic test_pg_monitor();
        req = 1'b1;
        tick(13);
        total++;
        if (outs() !== {3'b111, 1'b1, 1'b0, 1'b0, 4'd0}) begin
            bad++; $display("FAIL mon_on got=%b exp=%b", outs(), {3'b111, 1'b1, 1'b0, 1'b0, 4'd0});
        end
        pg = 3'b101;
        tick(2);
        total++;
`ifdef CAM_PG_MONITOR_EN
        if (outs() !== {3'b000, 1'b0, 1'b0, 1'b1, 4'd1}) begin
            bad++; $display("FAIL mon_trip got=%b exp=%b", outs(), {3'b000, 1'b0, 1'b0, 1'b1, 4'd1});
        end
        pg = 3'b111; req = 1'b0; clr = 1'b1;
        tick(1);
        clr = 1'b0;
`else
        if (outs() !== {3'b111, 1'b1, 1'b0, 1'b0, 4'd0}) begin
            bad++; $display("FAIL mon_ignored got=%b exp=%b", outs(), {3'b111, 1'b1, 1'b0, 1'b0, 4'd0});
        end
        pg = 3'b111; req = 1'b0;
        tick(13);
`endif
        total++;
        if (outs() !== {3'b000, 1'b0, 1'b0, 1'b0, fs}) begin
            bad++; $display("FAIL mon_end got=%b exp=%b", outs(), {3'b000, 1'b0, 1'b0, 1'b0, fs});
        end
    endtask

    task automatic test_random();
        logic [9:0] exp;
        logic [2:0] e_en;
        rstn = 1'b0; req = 1'b0; clr = 1'b0; pg = 3'b111;
        tick(1);
        model_step(1'b0, req, clr, pg);
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) req = ~req;
            if ($urandom_range(0, 15) == 0) pg = ($urandom_range(0, 2) == 0) ? 3'($urandom) : 3'b111;
            clr  = ($urandom_range(0, 7) == 0);
            rstn = ($urandom_range(0, 399) != 0);
            tick(1);
            model_step(rstn, req, clr, pg);
            e_en = 3'((1 << m_lv) - 1);
            exp = {e_en, m_ph == P_ON, (m_ph == P_UP) || (m_ph == P_DN), m_flt, 4'(m_fs)};
            total++;
            if (outs() !== exp) begin
                bad++; $display("FAIL random cyc=%0d got=%b exp=%b", c, outs(), exp);
            end
        end
        rstn = 1'b1;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_power_down();
        test_timeout();
        test_slow_pg();
        test_reversal();
        test_pg_monitor();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/camera_power_sequencer.md
Name: camera_power_sequencer

Overview:
Parametrised successor to the fixed five-step camera power-on sequencer. Drives NUM_STEPS enable outputs (regulators, XCLR, INCK_EN, ...) in ascending order on power-up and descending order on power-down, with a programmable inter-step delay. Each step is gated by a per-step power-good input with a timeout-to-fault. Supports request reversal mid-sequence. Sits between the board-control/NIOS register block and the camera power pins.

Parameters:
NUM_STEPS, 5, number of sequenced enables (1..16); bit 0 is enabled first and disabled last
STEP_DELAY, 1000000, minimum ctrl_clk_i cycles between consecutive enable edges (>=1)
PG_TIMEOUT, 2000000, cycles allowed for pg_i[idx] after enabling step idx (must be > STEP_DELAY)
CNT_W, 32, step counter width; must hold PG_TIMEOUT

Ports:
ctrl_clk_i  in  1  control clock
ctrl_rst_n_i  in  1  reset; synchronous, active-low
pwr_req_i  in  1  1 = power up / stay on, 0 = power down / stay off (level)
pg_i  in  NUM_STEPS  per-step power-good/ack; tie bit high for steps without feedback
fault_clr_i  in  1  single-cycle fault clear
en_o  out  NUM_STEPS  sequenced enables, registered
pwr_up_o  out  1  all steps on and sequence complete
busy_o  out  1  ramping up or down
fault_o  out  1  power-good timeout (or loss, see option) latched
fault_step_o  out  4  index of the step that faulted

Behaviour:
- Reset (ctrl_rst_n_i low at a clock edge): state OFF, idx=0, cnt=0, en_o=0, pwr_up_o=0, busy_o=0, fault_o=0, fault_step_o=0. Reset mid-sequence drops all enables on that edge, with no ramp-down.
- States: OFF, RAMP_UP, ON, RAMP_DOWN, FAULT. All outputs are registered and updated on the same edge as the state change.
- OFF, pwr_req_i=1 -> RAMP_UP: idx=0, en_o[0]=1, cnt=0, busy_o=1.
- RAMP_UP: cnt increments each cycle, saturating at 2^CNT_W-1.
  - Advance when cnt>=STEP_DELAY-1 and pg_i[idx]=1.
  - If idx=NUM_STEPS-1 -> ON: pwr_up_o=1, busy_o=0.
  - Otherwise idx+1, set en_o[idx+1], cnt=0.
  - Consecutive enables are therefore STEP_DELAY cycles apart when pg_i is already high.
- RAMP_UP timeout: cnt=PG_TIMEOUT-1 and pg_i[idx]=0 -> FAULT.
- ON: hold. pwr_req_i=0 -> RAMP_DOWN: idx=NUM_STEPS-1, clear en_o[idx], cnt=0, pwr_up_o=0, busy_o=1.
- RAMP_DOWN: no pg check.
  - At cnt=STEP_DELAY-1: if idx=0 -> OFF, busy_o=0.
  - Otherwise idx-1, clear en_o[idx-1], cnt=0.
- Reversal:
  - RAMP_UP with pwr_req_i=0 -> RAMP_DOWN at the same idx (clear en_o[idx], cnt=0).
  - RAMP_DOWN with pwr_req_i=1 -> RAMP_UP at the same idx (set en_o[idx], cnt=0).
  - Reversal takes priority over step advance and over timeout in the same cycle.
- FAULT entry: en_o=0 (all at once), fault_o=1, fault_step_o=idx, busy_o=0, pwr_up_o=0.
- FAULT exit: leave to OFF only when fault_clr_i=1 and pwr_req_i=0 in the same cycle; this clears fault_o. fault_step_o holds until the next fault or reset. fault_clr_i is ignored outside FAULT.
- Invariant: en_o is always a contiguous run of ones from bit 0 (thermometer code).

Optional Feature:
CAM_PG_MONITOR_EN
- Defined: in ON, any pg_i bit low for 2 consecutive cycles -> FAULT; fault_step_o = lowest low bit.
- Undefined: pg_i is ignored in ON, RAMP_DOWN, OFF and FAULT.

Test Plan:
Common settings: NUM_STEPS=3, STEP_DELAY=4, PG_TIMEOUT=10, pg_i=3'b111 unless stated. E = first edge sampling pwr_req_i=1.
- Power-up: en_o=001@E, 011@E+4, 111@E+8; pwr_up_o=1 and busy_o=0 @E+12.
- Power-down from ON, D = first edge sampling req=0: en_o=011@D, 001@D+4, 000@D+8; OFF with busy_o=0 @D+12.
- Timeout: pg_i[1]=0 -> en_o=011@E+4; FAULT @E+14 with en_o=000, fault_o=1, fault_step_o=1. fault_clr_i with req=1 has no effect; with req=0 -> OFF and fault_o=0.
- Slow pg: pg_i[2] rises at E+15 -> en_o stays 111 and pwr_up_o=1 on the edge after pg is sampled high; no fault.
- Reversal: req drops at E+5 (en_o=011) -> en_o=001 next edge, 000 four cycles later, OFF four cycles after that. Then reset asserted mid-ramp -> all outputs 0 on that edge.
- CAM_PG_MONITOR_EN: in ON, pg_i=101 for 2 cycles -> fault_o=1, fault_step_o=1, en_o=000. With the macro undefined -> stays ON.
